mem_copy_master: RTL and testbench
==================================

# mem_copy_master

Avalon-MM master that copies a block of 32-bit words inside on-chip memory: reads each word from a source address, then writes it to a destination address, one word at a time. It drives the slave port of the on-chip RAM (14-bit word address, 4-bit byteenable, fixed read latency) on behalf of a simple start/done command interface. It offloads buffer moves from the Nios CPU, for example relocating SPI receive buffers. It also reports a running checksum of the copied data.

## Interface
- ADDR_W, 14: word-address width of the memory slave
- DATA_W, 32: data width; byteenable width is DATA_W/8
- LEN_W, 15: width of the word-count input
- READ_LATENCY, 1: cycles from read acceptance to valid m_readdata; legal range is 1 or more
- clk  in  1  single clock; every register updates on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command strobe; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- len  in  LEN_W  number of words to copy
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the copy completes
- checksum  out  DATA_W  sum mod 2^DATA_W of the words copied by the current or last command
- m_address  out  ADDR_W  master word address
- m_read  out  1  read request
- m_write  out  1  write request
- m_byteenable  out  DATA_W/8  all-ones whenever m_read or m_write is high, zero otherwise
- m_writedata  out  DATA_W  captured read word
- m_readdata  in  DATA_W  slave read data
- m_waitrequest  in  1  slave stall; tie to 0 for on-chip RAM

## Operation
- States: IDLE, RD, RWAIT, WR, DONE.
- **IDLE**
  - start=1 and len≠0: latch src, dst and len; clear checksum and the word index i; go to RD.
  - start=1 and len=0: go to DONE directly. No bus activity occurs, and checksum is cleared to 0.
- **RD**
  - Drive m_read=1 and m_address=src+i.
  - The read is accepted in the cycle where m_read=1 and m_waitrequest=0; then go to RWAIT.
  - While m_waitrequest=1, hold all master outputs stable.
- **RWAIT**
  - Stay READ_LATENCY cycles with m_read=0.
  - In the last of these cycles, capture m_readdata into the data register and add it to checksum.
  - Then go to WR.
- **WR**
  - Drive m_write=1, m_address=dst+i and m_writedata=captured word. Hold them while m_waitrequest=1.
  - On acceptance, increment i. If i=len go to DONE, else go to RD.
- **DONE**: done=1 for exactly one cycle, then go to IDLE.
- Address arithmetic: src+i and dst+i are computed modulo 2^ADDR_W, so addresses wrap at the top of memory (e.g. 0x3FFF→0x0000).
- Overlapping ranges: each word's read completes before its write, in ascending order. For dst>src with overlap, this propagates already-copied words; that behaviour is specified and not an error.
- start while busy is ignored. src_addr, dst_addr and len are not re-sampled.
- m_read and m_write are never high in the same cycle.
- Reset, including mid-transfer:
  - The next state is IDLE.
  - m_read, m_write, busy and done are 0.
  - m_address, m_writedata and checksum are 0; m_byteenable is 0.
  - A pending slave transaction is abandoned.

## Timing
- start sampled at edge k: m_read=1 during cycle k+1.
- With m_waitrequest=0 and READ_LATENCY=1, each word takes 3 cycles: RD, RWAIT, WR.
- For N words, the last write occurs in cycle k+3N. done=1 in cycle k+3N+1, and busy=0 from cycle k+3N+2.
- Each stall cycle adds exactly one cycle. Each extra latency cycle adds one cycle per word.
- len=0: done=1 in cycle k+1, with busy=1 in that cycle only.
- checksum is final in the DONE cycle and holds until the next accepted start.
- A new start is accepted in the cycle after DONE (IDLE) at the earliest.

## Test plan
- **Basic copy**
  - Stimulus: RAM model with latency 1 holding 0x11111111, 0x22222222, 0x33333333 at 0x0010–0x0012; start with src=0x0010, dst=0x0100, len=3.
  - Response: writes of those values to 0x0100–0x0102; done in cycle k+10; checksum=0x66666666.
- **Wait states**
  - Stimulus: m_waitrequest high for 2 cycles on every read and every write; len=2.
  - Response: outputs held stable during stalls; done in cycle k+15; data copied correctly.
- **Wrap and zero length**
  - Stimulus: src=0x3FFF, dst=0x0000, len=2, words 0xFFFFFFFF and 0x00000002; then a second start with len=0.
  - Response: reads at 0x3FFF then 0x0000; checksum=0x00000001; second command gives done in cycle k+1 with no m_read or m_write.
- **Start while busy and overlap**
  - Stimulus: src=0x0000, dst=0x0001, len=4, with RAM[0]=0xA5A5A5A5; pulse start again mid-copy.
  - Response: second start ignored; RAM[1..4] all end as 0xA5A5A5A5.
- **Reset mid-copy**
  - Stimulus: assert reset during the WR of word 2 of 5.
  - Response: next cycle all outputs are 0 and the state is IDLE. A fresh start then completes normally with a correct checksum.
- **READ_LATENCY=3**
  - Stimulus: len=2 with a matching latency-3 slave model.
  - Response: 5 cycles per word; done in cycle k+11; correct data captured.

Source files
------------

// File: rtl/mem_copy_master_if.sv
// rtl/mem_copy_master_if.sv - Avalon-MM master bus bundle for mem_copy_master
//
// m_address     word address driven by the master
// m_read        read request
// m_write       write request
// m_byteenable  byte lanes, all-ones while a request is active
// m_writedata   write data
// m_readdata    read data returned by the slave
// m_waitrequest slave stall
interface mem_copy_master_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_address;
    logic                m_read;
    logic                m_write;
    logic [DATA_W/8-1:0] m_byteenable;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_waitrequest;

    modport master (
        output m_address, m_read, m_write, m_byteenable, m_writedata,
        input  m_readdata, m_waitrequest
    );

    modport slave (
        input  m_address, m_read, m_write, m_byteenable, m_writedata,
        output m_readdata, m_waitrequest
    );
endinterface

// File: rtl/mem_copy_master.sv
// rtl/mem_copy_master.sv - word-by-word memory copy engine with running checksum
//
// clk, reset         single clock, synchronous active-high reset
// start              command strobe, sampled only while idle
// src_addr, dst_addr first source / destination word address
// len                number of words to copy (0 completes immediately)
// busy               high from the cycle after start acceptance through the done cycle
// done               one-cycle completion pulse
// checksum           sum of copied words, modulo 2^DATA_W
// m                  Avalon-MM master port toward the memory slave
module mem_copy_master #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 15,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    mem_copy_master_if.master m
);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] src_r, dst_r;
    logic [LEN_W-1:0]  len_r, idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] sum_r;

    logic [LEN_W-1:0]  idx_inc;
    logic              lat_last;

    assign idx_inc  = idx + LEN_W'(1);
    // Last RWAIT cycle is when the slave presents read data.
    assign lat_last = (lat_cnt == LAT_W'(READ_LATENCY - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len == '0) ? DONE : RD;
            RD:      if (!m.m_waitrequest) state_next = RWAIT;
            RWAIT:   if (lat_last) state_next = WR;
            WR:      if (!m.m_waitrequest) state_next = (idx_inc == len_r) ? DONE : RD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            idx     <= '0;
            lat_cnt <= '0;
            data_r  <= '0;
            sum_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r <= src_addr;
                        dst_r <= dst_addr;
                        len_r <= len;
                        idx   <= '0;
                        sum_r <= '0;
                    end
                end
                RD: begin
                    if (!m.m_waitrequest) lat_cnt <= '0;
                end
                RWAIT: begin
                    if (lat_last) begin
                        data_r <= m.m_readdata;
                        sum_r  <= sum_r + m.m_readdata;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                WR: begin
                    if (!m.m_waitrequest) idx <= idx_inc;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode straight from state and held registers, so they stay
    // stable for as long as the slave stalls.
    always_comb begin
        m.m_read    = (state == RD);
        m.m_write   = (state == WR);
        m.m_address = '0;
        if (state == RD) m.m_address = src_r + ADDR_W'(idx);
        if (state == WR) m.m_address = dst_r + ADDR_W'(idx);
    end

    assign m.m_byteenable = {(DATA_W/8){m.m_read | m.m_write}};
    assign m.m_writedata  = data_r;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign checksum       = sum_r;
endmodule

// File: tb/tb_mem_copy_master.sv
// tb/tb_mem_copy_master.sv - directed self-checking bench for mem_copy_master
module tb_mem_copy_master;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start1, start3;
    logic [13:0] src_addr, dst_addr;
    logic [14:0] len;
    logic        busy1, done1, busy3, done3;
    logic [31:0] cs1, cs3;

    mem_copy_master_if #(.ADDR_W(14), .DATA_W(32)) bus1 ();
    mem_copy_master_if #(.ADDR_W(14), .DATA_W(32)) bus3 ();

    mem_copy_master #(.ADDR_W(14), .DATA_W(32), .LEN_W(15), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy1), .done(done1), .checksum(cs1), .m(bus1.master));

    mem_copy_master #(.ADDR_W(14), .DATA_W(32), .LEN_W(15), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy3), .done(done3), .checksum(cs3), .m(bus3.master));

    logic [31:0] mem [0:16383];
    logic        pl_en;
    logic [13:0] pl_addr;
    logic [31:0] pl_data;
    logic        stall_en;
    logic [1:0]  stall_cnt = 2'd0;
    logic [31:0] rd1;
    logic [31:0] rd3 [0:2];
    int          n_ops = 0;
    logic [13:0] rd_log [$];
    logic [13:0] wr_log [$];
    int          vectors = 0;
    int          miscompares = 0;

    logic req1, acc_rd1, acc_wr1;
    assign req1    = bus1.m_read | bus1.m_write;
    assign bus1.m_waitrequest = stall_en && req1 && (stall_cnt < 2'd2);
    assign acc_rd1 = bus1.m_read & ~bus1.m_waitrequest;
    assign acc_wr1 = bus1.m_write & ~bus1.m_waitrequest;
    assign bus1.m_readdata    = rd1;
    assign bus3.m_waitrequest = 1'b0;
    assign bus3.m_readdata    = rd3[2];

    // Memory model: latency-1 port for dut1, latency-3 port for dut3.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (acc_wr1) mem[bus1.m_address] <= bus1.m_writedata;
        if (bus3.m_write) mem[bus3.m_address] <= bus3.m_writedata;
        if (acc_rd1) rd1 <= mem[bus1.m_address];
        rd3[0] <= mem[bus3.m_address];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
        stall_cnt <= (req1 && bus1.m_waitrequest) ? stall_cnt + 2'd1 : 2'd0;
        n_ops <= n_ops + int'(acc_rd1) + int'(acc_wr1) + int'(bus3.m_read) + int'(bus3.m_write);
        if (acc_rd1) rd_log.push_back(bus1.m_address);
        if (acc_wr1) wr_log.push_back(bus1.m_address);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus protocol monitor on dut1: stall hold, read/write exclusivity, byteenable.
    logic        p_stall = 1'b0, p_rd, p_wr;
    logic [13:0] p_addr;
    logic [31:0] p_wdata;
    always @(negedge clk) begin
        if (p_stall && !reset) begin
            check("hold_addr", bus1.m_address, p_addr);
            check("hold_rd", bus1.m_read, p_rd);
            check("hold_wr", bus1.m_write, p_wr);
            check("hold_wdata", bus1.m_writedata, p_wdata);
        end
        check("rd_wr_excl", bus1.m_read & bus1.m_write, 1'b0);
        check("byteenable", bus1.m_byteenable, req1 ? 4'hF : 4'h0);
        p_stall <= bus1.m_waitrequest;
        p_addr  <= bus1.m_address;
        p_rd    <= bus1.m_read;
        p_wr    <= bus1.m_write;
        p_wdata <= bus1.m_writedata;
    end

    task automatic poke(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Issues a command and returns n, the cycle offset (k+n) at which done is seen.
    task automatic run_cmd(input bit use3, input logic [13:0] s, input logic [13:0] d,
                           input logic [14:0] l, input int pulse_at, output int n);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        n = 1;
        while (!(use3 ? done3 : done1) && n < 300) begin
            if (n == pulse_at) begin
                start1 = 1'b1; src_addr = 14'h0200; len = 15'd1;
            end
            @(negedge clk);
            start1 = 1'b0;
            n++;
        end
        if (n >= 300) n = -1;
    endtask

    int n, ops_before;

    initial begin
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0; pl_en = 1'b0; stall_en = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_cs", cs1, 32'h0);
        check("rst_addr", bus1.m_address, 14'h0);
        check("rst_wdata", bus1.m_writedata, 32'h0);
        check("rst_rw", {bus1.m_read, bus1.m_write}, 2'b00);
        reset = 1'b0;

        poke(14'h0010, 32'h11111111);
        poke(14'h0011, 32'h22222222);
        poke(14'h0012, 32'h33333333);
        poke(14'h0013, 32'h44444444);
        poke(14'h0014, 32'h55555555);
        poke(14'h3FFF, 32'hFFFFFFFF);
        poke(14'h0000, 32'h00000002);

        // Basic copy
        wr_log.delete();
        run_cmd(1'b0, 14'h0010, 14'h0100, 15'd3, -1, n);
        check("basic_done_cyc", n, 10);
        check("basic_busy_at_done", busy1, 1'b1);
        check("basic_cs", cs1, 32'h66666666);
        check("basic_nwr", wr_log.size(), 3);
        check("basic_wr0_addr", wr_log[0], 14'h0100);
        check("basic_wr2_addr", wr_log[2], 14'h0102);
        @(negedge clk);
        check("basic_done_pulse", done1, 1'b0);
        check("basic_busy_after", busy1, 1'b0);
        check("basic_cs_hold", cs1, 32'h66666666);
        check("basic_m0", mem[14'h0100], 32'h11111111);
        check("basic_m1", mem[14'h0101], 32'h22222222);
        check("basic_m2", mem[14'h0102], 32'h33333333);

        // Wait states: two stall cycles on every read and write
        stall_en = 1'b1;
        run_cmd(1'b0, 14'h0010, 14'h0300, 15'd2, -1, n);
        check("wait_done_cyc", n, 15);
        check("wait_cs", cs1, 32'h33333333);
        @(negedge clk);
        stall_en = 1'b0;
        check("wait_m0", mem[14'h0300], 32'h11111111);
        check("wait_m1", mem[14'h0301], 32'h22222222);

        // Source address wrap at top of memory
        rd_log.delete();
        run_cmd(1'b0, 14'h3FFF, 14'h0500, 15'd2, -1, n);
        check("wrap_done_cyc", n, 7);
        check("wrap_cs", cs1, 32'h00000001);
        check("wrap_rd0", rd_log[0], 14'h3FFF);
        check("wrap_rd1", rd_log[1], 14'h0000);
        @(negedge clk);
        check("wrap_m0", mem[14'h0500], 32'hFFFFFFFF);
        check("wrap_m1", mem[14'h0501], 32'h00000002);

        // Zero length
        ops_before = n_ops;
        run_cmd(1'b0, 14'h0010, 14'h0600, 15'd0, -1, n);
        check("zero_done_cyc", n, 1);
        check("zero_busy", busy1, 1'b1);
        check("zero_cs", cs1, 32'h0);
        @(negedge clk);
        check("zero_no_bus", n_ops, ops_before);
        check("zero_busy_after", busy1, 1'b0);

        // Overlapping copy with a start pulse mid-transfer
        poke(14'h0000, 32'hA5A5A5A5);
        run_cmd(1'b0, 14'h0000, 14'h0001, 15'd4, 5, n);
        check("ovl_done_cyc", n, 13);
        check("ovl_cs", cs1, 32'h96969694);
        @(negedge clk);
        check("ovl_restart_ignored", busy1, 1'b0);
        for (int i = 1; i <= 4; i++) check("ovl_mem", mem[i], 32'hA5A5A5A5);

        // Reset during the write of word 2 of 5
        @(negedge clk);
        src_addr = 14'h0010; dst_addr = 14'h0700; len = 15'd5; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid_wr", bus1.m_write, 1'b1);
        check("rstmid_addr", bus1.m_address, 14'h0701);
        check("rstmid_wdata", bus1.m_writedata, 32'h22222222);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_rw", {bus1.m_read, bus1.m_write}, 2'b00);
        check("rstmid_busy_done", {busy1, done1}, 2'b00);
        check("rstmid_addr0", bus1.m_address, 14'h0);
        check("rstmid_wdata0", bus1.m_writedata, 32'h0);
        check("rstmid_cs0", cs1, 32'h0);
        check("rstmid_be0", bus1.m_byteenable, 4'h0);
        reset = 1'b0;
        run_cmd(1'b0, 14'h0010, 14'h0700, 15'd3, -1, n);
        check("rstmid_redo_cyc", n, 10);
        check("rstmid_redo_cs", cs1, 32'h66666666);

        // Latency-3 slave
        run_cmd(1'b1, 14'h0010, 14'h0400, 15'd2, -1, n);
        check("lat3_done_cyc", n, 11);
        check("lat3_cs", cs3, 32'h33333333);
        @(negedge clk);
        check("lat3_m0", mem[14'h0400], 32'h11111111);
        check("lat3_m1", mem[14'h0401], 32'h22222222);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
